bytecode_sequencer: RTL

Multi-cycle fetch/decode/execute controller for the bytecode core. Fetches opcode bytes from synchronous program memory, presents them to the combinational opcode decoder, then uses the decoder's argument, stack and writeback information to fetch operand bytes, pop operands and start the execution unit. It also pushes results and computes the next PC, including GOTO and taken conditional branches. It sits between program memory, the decoder, the operand stack and the ALU/comparator.

---
 rtl/bytecode_sequencer.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bytecode_sequencer.sv
// bytecode_sequencer: multi-cycle fetch/decode/execute controller for the
// bytecode core. Reads opcode and inline argument bytes from synchronous
// program memory, pops stack operands, starts the execution unit, pushes the
// result and computes the next PC (GOTO and taken conditional branches).
// Optional feature: define BYTECODE_SEQ_SINGLESTEP_EN to add the 'step' input
// and a HOLD state entered after every writeback.
module bytecode_sequencer #(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
`ifdef BYTECODE_SEQ_SINGLESTEP_EN
    input  logic                step,
`endif
    output logic [PC_WIDTH-1:0] prog_addr,
    output logic                prog_rd,
    input  logic [7:0]          prog_data,
    output logic [7:0]          opcode,
    input  logic [1:0]          dec_argc,
    input  logic [1:0]          dec_stackargs,
    input  logic                dec_stackwb,
    input  logic                dec_isgoto,
    input  logic                dec_iscmp,
    output logic [15:0]         arg,
    output logic                stack_pop,
    output logic                stack_push,
    input  logic                stack_empty,
    output logic                exec_start,
    input  logic                exec_done,
    input  logic                cmp_taken,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                halted,
    output logic                fault
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_ARG_RD,
        S_ARG_LAT,
        S_POP,
        S_EXEC,
        S_WAIT,
        S_WB,
`ifdef BYTECODE_SEQ_SINGLESTEP_EN
        S_HOLD,
`endif
        S_FAULT
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_insn_pc;
    logic [7:0]            r_opcode;
    logic [15:0]           r_arg;
    logic [1:0]            r_argn;
    logic [1:0]            r_popn;
    logic                  r_taken;
    logic                  r_prog_rd;
    logic                  r_exec_start;
    logic                  r_stack_push;

    logic                  w_is_ret;
    logic                  w_arg_last;
    logic                  w_pop_last;
    logic                  w_no_args;
    logic                  w_no_pops;
    logic                  w_pop_ok;
    logic                  w_branch;
    logic [15:0]           w_arg_sx;
    logic [PC_WIDTH-1:0]   w_off;
    logic [PC_WIDTH-1:0]   w_target;

    // Return opcodes end the program: no execution, just a halted pulse.
    assign w_is_ret   = (r_opcode == 8'hAC) || (r_opcode == 8'hB0) || (r_opcode == 8'hB1);
    assign w_no_args  = (dec_argc == 2'd0);
    assign w_no_pops  = (dec_stackargs == 2'd0);
    assign w_arg_last = ((r_argn + 2'd1) == dec_argc);
    assign w_pop_last = ((r_popn + 2'd1) == dec_stackargs);

    // A pop is only issued while the stack has something to give; an empty
    // stack in POP is an underflow and the pop is suppressed.
    assign w_pop_ok   = (r_state == S_POP) && !stack_empty;

    // Branch offset: a single argument byte is a signed 8-bit displacement.
    assign w_arg_sx   = (dec_argc == 2'd1) ? {{8{r_arg[7]}}, r_arg[7:0]} : r_arg;

    if (PC_WIDTH > 16) begin : g_off_sx
        assign w_off = {{(PC_WIDTH-16){w_arg_sx[15]}}, w_arg_sx};
    end else begin : g_off_tr
        assign w_off = w_arg_sx[PC_WIDTH-1:0];
    end

    // Branch target is relative to the opcode address, modulo 2^PC_WIDTH.
    assign w_target   = r_insn_pc + w_off;
    assign w_branch   = dec_isgoto || (dec_iscmp && r_taken);

    assign prog_addr  = r_pc;
    assign pc         = r_pc;
    assign prog_rd    = r_prog_rd;
    assign opcode     = r_opcode;
    assign arg        = r_arg;
    assign exec_start = r_exec_start;
    assign stack_push = r_stack_push;
    assign stack_pop  = w_pop_ok;
    assign busy       = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign fault      = (r_state == S_FAULT);

    // halted marks the cycle that hands control back to IDLE: the last pop of
    // a return, or the decode/argument cycle when there is nothing to pop.
    assign halted     = w_is_ret &&
                        (((r_state == S_DECODE)  && w_no_args && w_no_pops) ||
                         ((r_state == S_ARG_LAT) && w_arg_last && w_no_pops) ||
                         (w_pop_ok && w_pop_last));

    // Sequencer FSM; strobes are registered on the transition into the state
    // that owns them so they are clean for the full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_insn_pc    <= '0;
            r_opcode     <= '0;
            r_arg        <= '0;
            r_argn       <= '0;
            r_popn       <= '0;
            r_taken      <= 1'b0;
            r_prog_rd    <= 1'b0;
            r_exec_start <= 1'b0;
            r_stack_push <= 1'b0;
        end else begin
            r_prog_rd    <= 1'b0;
            r_exec_start <= 1'b0;
            r_stack_push <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state   <= S_FETCH;
                        r_prog_rd <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_insn_pc <= r_pc;
                    r_state   <= S_LATCH;
                end
                S_LATCH: begin
                    r_opcode <= prog_data;
                    r_pc     <= r_pc + PC_ONE;
                    r_arg    <= '0;
                    r_argn   <= '0;
                    r_popn   <= '0;
                    r_state  <= S_DECODE;
                end
                S_DECODE: begin
                    if (!w_no_args) begin
                        r_state   <= S_ARG_RD;
                        r_prog_rd <= 1'b1;
                    end else if (!w_no_pops) begin
                        r_state <= S_POP;
                    end else if (w_is_ret) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state      <= S_EXEC;
                        r_exec_start <= 1'b1;
                    end
                end
                S_ARG_RD: begin
                    r_pc    <= r_pc + PC_ONE;
                    r_state <= S_ARG_LAT;
                end
                S_ARG_LAT: begin
                    r_arg  <= {r_arg[7:0], prog_data};
                    r_argn <= r_argn + 2'd1;
                    if (!w_arg_last) begin
                        r_state   <= S_ARG_RD;
                        r_prog_rd <= 1'b1;
                    end else if (!w_no_pops) begin
                        r_state <= S_POP;
                    end else if (w_is_ret) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state      <= S_EXEC;
                        r_exec_start <= 1'b1;
                    end
                end
                S_POP: begin
                    if (stack_empty) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_popn <= r_popn + 2'd1;
                        if (w_pop_last) begin
                            if (w_is_ret) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state      <= S_EXEC;
                                r_exec_start <= 1'b1;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (exec_done) begin
                        r_taken      <= cmp_taken;
                        r_stack_push <= dec_stackwb;
                        r_state      <= S_WB;
                    end
                end
                S_WB: begin
                    if (w_branch) begin
                        r_pc <= w_target;
                    end
`ifdef BYTECODE_SEQ_SINGLESTEP_EN
                    r_state <= S_HOLD;
`else
                    if (run) begin
                        r_state   <= S_FETCH;
                        r_prog_rd <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
`endif
                end
`ifdef BYTECODE_SEQ_SINGLESTEP_EN
                S_HOLD: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                    end else if (step) begin
                        r_state   <= S_FETCH;
                        r_prog_rd <= 1'b1;
                    end
                end
`endif
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
